// File: rtl/serial_ripple_adder_pkg.sv
// Shared types and helpers for the serial ripple adder.
// Holds the FSM state encoding and the chunk-counter width calculation.
package serial_ripple_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2. Returns 0 for n <= 1, so callers clamp to at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_ripple_adder_ripple_chunk.sv
// Combinational ripple of BITS_PER_CYCLE full-adder cells.
// Also exports the carry into the top bit so the caller can form signed overflow.
module ripple_chunk #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a,
  input  logic [BITS_PER_CYCLE-1:0] b,
  input  logic                      ci,
  output logic [BITS_PER_CYCLE-1:0] s,
  output logic                      co,
  output logic                      c_top
);

  logic [BITS_PER_CYCLE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[BITS_PER_CYCLE];
  assign c_top = c[BITS_PER_CYCLE-1];

endmodule

// File: rtl/serial_ripple_adder.sv
// Multi-cycle adder/subtractor: adds BITS_PER_CYCLE bits per clock, LSB chunk first,
// and presents sum/cout/ovf with a one-cycle done pulse.
module serial_ripple_adder
  import serial_ripple_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("serial_ripple_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  // Handshake: start is accepted only in IDLE or DONE (ignored while busy);
  // done is a one-cycle pulse and sum/cout/ovf hold until the next done.
  state_t              state_q, state_d;
  logic                take, last;
  logic [WIDTH-1:0]    a_q, b_q, res_q, res_d;
  logic [CW-1:0]       cnt_q;
  logic                carry_q;
  logic [BITS_PER_CYCLE-1:0] chunk_s;
  logic                chunk_co, chunk_ctop;

  ripple_chunk #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_chunk (
    .a    (a_q[BITS_PER_CYCLE-1:0]),
    .b    (b_q[BITS_PER_CYCLE-1:0]),
    .ci   (carry_q),
    .s    (chunk_s),
    .co   (chunk_co),
    .c_top(chunk_ctop)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          take    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          take    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result shifts in from the top so the final chunk lands in the MSBs.
  always_comb begin
    res_d = res_q >> BITS_PER_CYCLE;
    res_d[WIDTH-1 -: BITS_PER_CYCLE] = chunk_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : cin;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> BITS_PER_CYCLE;
        b_q     <= b_q >> BITS_PER_CYCLE;
        carry_q <= chunk_co;
        res_q   <= res_d;
        cnt_q   <= last ? '0 : cnt_q + CW'(1);
        if (last) begin
          sum  <= res_d;
          cout <= chunk_co;
          ovf  <= chunk_co ^ chunk_ctop;
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed bench for serial_ripple_adder: one instance at 1 bit/cycle, one at 4 bits/cycle.
// Stimulus pushes expected results; per-instance monitors pop and compare on done.
module tb_serial_ripple_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  // Instance 1: BITS_PER_CYCLE = 1
  logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  // Instance 2: BITS_PER_CYCLE = 4
  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  serial_ripple_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_ripple_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Expected {sum, cout, ovf} and the cycle count at which done must be seen.
  logic [9:0] exp_q1[$];
  int         cyc_q1[$];
  logic [9:0] exp_q4[$];
  int         cyc_q4[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue1(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        input logic icin, input logic push, input logic [9:0] exp);
    start1 = 1'b1; a1 = ia; b1 = ib; sub1 = isub; cin1 = icin;
    if (push) begin
      exp_q1.push_back(exp);
      cyc_q1.push_back(cyc + 1 + 8);
    end
    tick();
    start1 = 1'b0;
    a1 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    sub1 = 1'($urandom_range(0, 1));
    cin1 = 1'($urandom_range(0, 1));
  endtask

  task automatic issue4(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        input logic icin, input logic push, input logic [9:0] exp);
    start4 = 1'b1; a4 = ia; b4 = ib; sub4 = isub; cin4 = icin;
    if (push) begin
      exp_q4.push_back(exp);
      cyc_q4.push_back(cyc + 1 + 2);
    end
    tick();
    start4 = 1'b0;
    a4 = 8'($urandom_range(0, 255));
    b4 = 8'($urandom_range(0, 255));
    sub4 = 1'($urandom_range(0, 1));
    cin4 = 1'($urandom_range(0, 1));
  endtask

  // Monitor for instance 1
  logic [9:0] hold1 = '0;
  int         brun1 = 0;
  logic       rpend1 = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rpend1) begin
        hold1 = '0;
        brun1 = 0;
      end
      if (done1) begin
        if (exp_q1.size() == 0) begin
          chk("d1_done_without_op", 0, 1);
        end else begin
          logic [9:0] e;
          int ec;
          e  = exp_q1.pop_front();
          ec = cyc_q1.pop_front();
          chk("d1_result", {sum1, cout1, ovf1}, e);
          chk("d1_latency", cyc, ec);
          chk("d1_busy_cycles", brun1, 8);
          hold1 = e;
        end
        brun1 = 0;
      end else begin
        chk("d1_hold", {sum1, cout1, ovf1}, hold1);
        if (busy1) brun1++;
        else brun1 = 0;
      end
      rpend1 = rst;
    end
  end

  // Monitor for instance 4
  logic [9:0] hold4 = '0;
  int         brun4 = 0;
  logic       rpend4 = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rpend4) begin
        hold4 = '0;
        brun4 = 0;
      end
      if (done4) begin
        if (exp_q4.size() == 0) begin
          chk("d4_done_without_op", 0, 1);
        end else begin
          logic [9:0] e;
          int ec;
          e  = exp_q4.pop_front();
          ec = cyc_q4.pop_front();
          chk("d4_result", {sum4, cout4, ovf4}, e);
          chk("d4_latency", cyc, ec);
          chk("d4_busy_cycles", brun4, 2);
          hold4 = e;
        end
        brun4 = 0;
      end else begin
        chk("d4_hold", {sum4, cout4, ovf4}, hold4);
        if (busy4) brun4++;
        else brun4 = 0;
      end
      rpend4 = rst;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_d1_outputs", {busy1, done1, sum1, cout1, ovf1}, 0);
    chk("reset_d4_outputs", {busy4, done4, sum4, cout4, ovf4}, 0);
    mon_en = 1'b1;
    tick();

    // Basic add with signed overflow
    issue1(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, {8'h96, 1'b0, 1'b1});
    repeat (10) tick();
    // Unsigned wrap with carry out
    issue1(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
    repeat (10) tick();
    // Subtract with borrow
    issue1(8'h10, 8'h20, 1'b1, 1'b0, 1'b1, {8'hF0, 1'b0, 1'b0});
    repeat (10) tick();
    // Subtract with signed overflow, then restart in the DONE cycle
    issue1(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
    repeat (8) tick();
    issue1(8'h33, 8'h44, 1'b0, 1'b1, 1'b1, {8'h78, 1'b0, 1'b0});
    repeat (10) tick();
    // Start pulsed in the third RUN cycle must be ignored
    issue1(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, {8'h46, 1'b0, 1'b0});
    repeat (2) tick();
    issue1(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, '0);
    repeat (10) tick();
    // Reset in the fourth RUN cycle abandons the operation
    issue1(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_d1_outputs", {busy1, done1, sum1, cout1, ovf1}, 0);
    repeat (12) tick();
    // More adds/subtracts after reset; cin must be ignored in sub mode
    issue1(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
    repeat (10) tick();
    issue1(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, {8'hFF, 1'b0, 1'b0});
    repeat (10) tick();
    issue1(8'h05, 8'h03, 1'b1, 1'b1, 1'b1, {8'h02, 1'b1, 1'b0});
    repeat (10) tick();

    // Four bits per cycle
    issue4(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, {8'hFF, 1'b1, 1'b0});
    repeat (4) tick();
    issue4(8'h70, 8'h10, 1'b0, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
    repeat (4) tick();
    issue4(8'h00, 8'h80, 1'b1, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
    repeat (2) tick();
    issue4(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, {8'h02, 1'b0, 1'b0});
    repeat (6) tick();

    chk("d1_queue_empty", exp_q1.size(), 0);
    chk("d4_queue_empty", exp_q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
